fnv_digest_reader: RTL and testbench
====================================

Name: fnv_digest_reader

Overview:
Read-side companion to the FNV-1a 32-bit hasher. On request, it snapshots the hasher's 32-bit digest into a shadow register. It then streams the digest out one byte at a time over a valid/ready byte interface to the I2C target's transmit path. When the full digest has been read, it can optionally pulse a clear request back to the hasher.

Parameters:
BIG_ENDIAN, 1, 1 = send most significant byte first (bits [31:24] first); 0 = least significant byte first.
CLEAR_AFTER_READ, 1, 1 = pulse hash_clear when the last byte transfers; 0 = hash_clear is tied low.

Ports:
clk  input  1  clock; all logic on the rising edge.
reset  input  1  synchronous, active-high reset.
hash_in  input  32  live digest from the hasher.
start  input  1  single-cycle request to snapshot hash_in and begin reading.
abort  input  1  cancels an in-progress read (I2C STOP or NACK).
tx_data  output  8  current digest byte.
tx_valid  output  1  tx_data is valid.
tx_ready  input  1  consumer accepts tx_data this cycle.
busy  output  1  a read is in progress.
done  output  1  one-cycle pulse after the final byte transfers.
hash_clear  output  1  one-cycle pulse requesting the hasher to reset to its offset basis.
byte_idx  output  3  number of bytes already transferred in the current read.

Behaviour:
- Reset (synchronous, active-high, clock clk): state=IDLE, shadow=0, byte_idx=0. tx_data, tx_valid, busy, done and hash_clear are all 0.
- States: IDLE, SEND, FINISH.
- IDLE:
  - busy=0, tx_valid=0, tx_data=0.
  - start=1 and abort=0: shadow<=hash_in, byte_idx<=0, next state SEND.
  - Latency: tx_valid=1 on the cycle after start.
- SEND:
  - busy=1, tx_valid=1.
  - tx_data = shadow byte selected by byte_idx and BIG_ENDIAN. For BIG_ENDIAN=1, idx0=[31:24] through idx3=[7:0].
  - A transfer occurs when tx_valid && tx_ready; byte_idx then increments.
  - tx_data and tx_valid are held stable while tx_ready=0.
  - A transfer of the last byte (byte_idx==3 with the feature off) moves to FINISH.
- FINISH (one cycle):
  - busy=0, tx_valid=0, done=1.
  - hash_clear=1 iff CLEAR_AFTER_READ.
  - Next state IDLE.
  - byte_idx holds its final count until the next start.
- start outside IDLE is ignored. The shadow does not change during a read, even if hash_in changes.
- abort in SEND:
  - Next state IDLE; no done, no hash_clear; byte_idx<=0.
  - abort takes priority over a same-cycle transfer; that byte counts as not sent.
- abort and start together in IDLE: abort wins and no read starts.
- abort in FINISH: ignored; done and hash_clear still pulse.
- Back-to-back reads: start in the FINISH cycle is ignored. start is accepted from the following IDLE cycle.
- Reset mid-read forces IDLE immediately on the next edge, with no done and no hash_clear.
- No combinational path from tx_ready to tx_valid or tx_data; both are driven from registered state.

Optional Feature:
FNV_READER_CHECKSUM_EN:
- Defined: a read is 5 bytes. The 5th byte is the XOR of the 4 digest bytes. The last-byte index becomes 4, byte_idx reaches 5 at done, and abort/clear rules are unchanged.
- Undefined: a read is exactly 4 bytes and no checksum logic is present.

Test Plan:
1. Empty-hash read: after reset, hash_in=0x811C9DC5, BIG_ENDIAN=1, tx_ready=1, start pulse. Required: tx_valid rises the next cycle; bytes 0x81,0x1C,0x9D,0xC5 on 4 consecutive cycles; done and hash_clear pulse 1 cycle. With FNV_READER_CHECKSUM_EN, a 5th byte 0xC5 follows.
2. Little-endian read: hash_in=0xE40C292C (hash of "a"), BIG_ENDIAN=0. Required: bytes 0x2C,0x29,0x0C,0xE4. With FNV_READER_CHECKSUM_EN, a 5th byte 0xED follows.
3. Backpressure and snapshot: tx_ready toggles 0/1 every cycle, and hash_in changes to 0x12345678 right after start. Required: each byte is held stable until accepted; the original snapshot bytes are sent; 8 cycles from first tx_valid to done.
4. Abort: abort asserted in the same cycle as the transfer of the 3rd byte. Required: IDLE next cycle, only 2 bytes counted, byte_idx=0, no done, no hash_clear.
5. start during busy is ignored (snapshot unchanged). Simultaneous start+abort in IDLE gives no read. CLEAR_AFTER_READ=0 gives hash_clear always 0.
6. Synchronous reset after the 1st byte: all outputs 0 the next cycle, busy=0, and a subsequent start reads the full digest correctly.

Source files
------------

// File: rtl/fnv_digest_reader.sv
// fnv_digest_reader: snapshots the FNV-1a 32-bit digest and streams it out
// byte by byte over a valid/ready interface, optionally pulsing a hasher clear.
//
// Ports:
//   clk, reset      - clock and synchronous active-high reset
//   hash_in         - live digest from the hasher
//   start, abort    - begin a read / cancel an in-progress read
//   tx_data/valid   - byte stream towards the I2C target transmit path
//   tx_ready        - consumer accepts tx_data this cycle
//   busy, done      - read in progress / one-cycle completion pulse
//   hash_clear      - one-cycle request to reset the hasher
//   byte_idx        - bytes already transferred in the current read
//
// Build option: define FNV_READER_CHECKSUM_EN to append a 5th byte holding
// the XOR of the four digest bytes.
module fnv_digest_reader #(
    parameter bit BIG_ENDIAN       = 1'b1,
    parameter bit CLEAR_AFTER_READ = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] hash_in,
    input  logic        start,
    input  logic        abort,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        done,
    output logic        hash_clear,
    output logic [2:0]  byte_idx
);

`ifdef FNV_READER_CHECKSUM_EN
    localparam logic [2:0] LAST_IDX = 3'd4;
`else
    localparam logic [2:0] LAST_IDX = 3'd3;
`endif

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND   = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t      state_q;
    logic [31:0] shadow_q;
    logic [2:0]  byte_idx_q;
    logic [7:0]  tx_data_q;
    logic        tx_valid_q;
    logic        busy_q;
    logic        done_q;
    logic        hash_clear_q;

    logic [2:0]  byte_idx_d;
    logic [7:0]  next_byte_d;

    function automatic logic [7:0] sel_byte(input logic [31:0] w,
                                            input logic [2:0]  idx);
        logic [7:0] b;
        b = 8'h00;
        case (idx)
            3'd0: b = BIG_ENDIAN ? w[31:24] : w[7:0];
            3'd1: b = BIG_ENDIAN ? w[23:16] : w[15:8];
            3'd2: b = BIG_ENDIAN ? w[15:8]  : w[23:16];
            3'd3: b = BIG_ENDIAN ? w[7:0]   : w[31:24];
`ifdef FNV_READER_CHECKSUM_EN
            3'd4: b = w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
`endif
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    assign byte_idx_d  = byte_idx_q + 3'd1;
    assign next_byte_d = sel_byte(shadow_q, byte_idx_d);

    // All outputs are registered so tx_ready never reaches tx_valid/tx_data
    // combinationally; tx_data is preloaded with the byte for the next index.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            shadow_q     <= 32'h0;
            byte_idx_q   <= 3'd0;
            tx_data_q    <= 8'h00;
            tx_valid_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            hash_clear_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q       <= 1'b0;
                    hash_clear_q <= 1'b0;
                    if (start && !abort) begin
                        state_q    <= SEND;
                        shadow_q   <= hash_in;
                        byte_idx_q <= 3'd0;
                        tx_data_q  <= sel_byte(hash_in, 3'd0);
                        tx_valid_q <= 1'b1;
                        busy_q     <= 1'b1;
                    end else begin
                        tx_data_q  <= 8'h00;
                        tx_valid_q <= 1'b0;
                        busy_q     <= 1'b0;
                    end
                end
                SEND: begin
                    // Abort beats a same-cycle transfer: that byte is dropped.
                    if (abort) begin
                        state_q    <= IDLE;
                        byte_idx_q <= 3'd0;
                        tx_data_q  <= 8'h00;
                        tx_valid_q <= 1'b0;
                        busy_q     <= 1'b0;
                    end else if (tx_ready) begin
                        byte_idx_q <= byte_idx_d;
                        if (byte_idx_q == LAST_IDX) begin
                            state_q      <= FINISH;
                            tx_data_q    <= 8'h00;
                            tx_valid_q   <= 1'b0;
                            busy_q       <= 1'b0;
                            done_q       <= 1'b1;
                            hash_clear_q <= CLEAR_AFTER_READ;
                        end else begin
                            tx_data_q <= next_byte_d;
                        end
                    end
                end
                FINISH: begin
                    state_q      <= IDLE;
                    done_q       <= 1'b0;
                    hash_clear_q <= 1'b0;
                    tx_data_q    <= 8'h00;
                    tx_valid_q   <= 1'b0;
                    busy_q       <= 1'b0;
                end
                default: begin
                    state_q      <= IDLE;
                    byte_idx_q   <= 3'd0;
                    tx_data_q    <= 8'h00;
                    tx_valid_q   <= 1'b0;
                    busy_q       <= 1'b0;
                    done_q       <= 1'b0;
                    hash_clear_q <= 1'b0;
                end
            endcase
        end
    end

    assign tx_data    = tx_data_q;
    assign tx_valid   = tx_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign hash_clear = hash_clear_q;
    assign byte_idx   = byte_idx_q;

endmodule

// File: tb/tb_fnv_digest_reader.sv
// tb_fnv_digest_reader: directed bench for fnv_digest_reader.
// Three instances share stimulus: big-endian, little-endian, no-clear.
module tb_fnv_digest_reader;

`ifdef FNV_READER_CHECKSUM_EN
    localparam int NB = 5;
`else
    localparam int NB = 4;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] hash_in;
    logic        start;
    logic        abort;
    logic        tx_ready;

    logic [7:0]  d0_data, d1_data, d2_data;
    logic        d0_valid, d1_valid, d2_valid;
    logic        d0_busy, d1_busy, d2_busy;
    logic        d0_done, d1_done, d2_done;
    logic        d0_clr, d1_clr, d2_clr;
    logic [2:0]  d0_idx, d1_idx, d2_idx;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    fnv_digest_reader #(.BIG_ENDIAN(1'b1), .CLEAR_AFTER_READ(1'b1)) dut (
        .clk(clk), .reset(reset), .hash_in(hash_in), .start(start),
        .abort(abort), .tx_data(d0_data), .tx_valid(d0_valid),
        .tx_ready(tx_ready), .busy(d0_busy), .done(d0_done),
        .hash_clear(d0_clr), .byte_idx(d0_idx)
    );

    fnv_digest_reader #(.BIG_ENDIAN(1'b0), .CLEAR_AFTER_READ(1'b1)) dut_le (
        .clk(clk), .reset(reset), .hash_in(hash_in), .start(start),
        .abort(abort), .tx_data(d1_data), .tx_valid(d1_valid),
        .tx_ready(tx_ready), .busy(d1_busy), .done(d1_done),
        .hash_clear(d1_clr), .byte_idx(d1_idx)
    );

    fnv_digest_reader #(.BIG_ENDIAN(1'b1), .CLEAR_AFTER_READ(1'b0)) dut_nc (
        .clk(clk), .reset(reset), .hash_in(hash_in), .start(start),
        .abort(abort), .tx_data(d2_data), .tx_valid(d2_valid),
        .tx_ready(tx_ready), .busy(d2_busy), .done(d2_done),
        .hash_clear(d2_clr), .byte_idx(d2_idx)
    );

    // Expected byte streams, most significant 8 bits = first byte.
    localparam logic [39:0] EMPTY_BE = 40'h81_1C_9D_C5_C5;
    localparam logic [39:0] EMPTY_LE = 40'hC5_9D_1C_81_C5;
    localparam logic [39:0] A_BE     = 40'hE4_0C_29_2C_ED;
    localparam logic [39:0] A_LE     = 40'h2C_29_0C_E4_ED;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pick(input logic [39:0] s, input int i);
        logic [39:0] t;
        t = s << (8 * i);
        return t[39:32];
    endfunction

    // Full read with tx_ready held high; start is driven for one cycle.
    task automatic run_read(input string tag, input logic [31:0] h,
                            input logic [39:0] be, input logic [39:0] le);
        hash_in = h;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < NB; i++) begin
            chk({tag, "_valid"}, {31'd0, d0_valid}, 32'd1);
            chk({tag, "_busy"}, {31'd0, d0_busy}, 32'd1);
            chk({tag, "_idx"}, {29'd0, d0_idx}, i);
            chk({tag, "_be"}, {24'd0, d0_data}, {24'd0, pick(be, i)});
            chk({tag, "_le"}, {24'd0, d1_data}, {24'd0, pick(le, i)});
            chk({tag, "_nc"}, {24'd0, d2_data}, {24'd0, pick(be, i)});
            chk({tag, "_done_lo"}, {31'd0, d0_done}, 32'd0);
            tick();
        end
        chk({tag, "_fin_done"}, {31'd0, d0_done}, 32'd1);
        chk({tag, "_fin_clr"}, {31'd0, d0_clr}, 32'd1);
        chk({tag, "_fin_clr_le"}, {31'd0, d1_clr}, 32'd1);
        chk({tag, "_fin_done_nc"}, {31'd0, d2_done}, 32'd1);
        chk({tag, "_fin_clr_nc"}, {31'd0, d2_clr}, 32'd0);
        chk({tag, "_fin_valid"}, {31'd0, d0_valid}, 32'd0);
        chk({tag, "_fin_busy"}, {31'd0, d0_busy}, 32'd0);
        chk({tag, "_fin_idx"}, {29'd0, d0_idx}, NB);
        tick();
        chk({tag, "_post_done"}, {31'd0, d0_done}, 32'd0);
        chk({tag, "_post_clr"}, {31'd0, d0_clr}, 32'd0);
        chk({tag, "_post_idx"}, {29'd0, d0_idx}, NB);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        tx_ready = 1'b1;
        hash_in = 32'h0;
        tick();
        tick();
        chk("rst_data", {24'd0, d0_data}, 32'd0);
        chk("rst_valid", {31'd0, d0_valid}, 32'd0);
        chk("rst_busy", {31'd0, d0_busy}, 32'd0);
        chk("rst_done", {31'd0, d0_done}, 32'd0);
        chk("rst_clr", {31'd0, d0_clr}, 32'd0);
        chk("rst_idx", {29'd0, d0_idx}, 32'd0);
        reset = 1'b0;
        tick();

        // 1: empty-hash read
        run_read("t1", 32'h811C9DC5, EMPTY_BE, EMPTY_LE);

        // 2: digest of "a"
        run_read("t2", 32'hE40C292C, A_BE, A_LE);

        // 3: backpressure, snapshot, start while busy, start in FINISH
        hash_in = 32'h811C9DC5;
        start = 1'b1;
        tick();
        start = 1'b0;
        hash_in = 32'h12345678;
        for (int c = 0; c < 2 * NB; c++) begin
            tx_ready = c[0];
            start = (c == 3);
            chk("t3_valid", {31'd0, d0_valid}, 32'd1);
            chk("t3_be", {24'd0, d0_data}, {24'd0, pick(EMPTY_BE, c / 2)});
            chk("t3_le", {24'd0, d1_data}, {24'd0, pick(EMPTY_LE, c / 2)});
            chk("t3_idx", {29'd0, d0_idx}, c / 2);
            tick();
        end
        start = 1'b1;
        tx_ready = 1'b1;
        chk("t3_done_at_8", {31'd0, d0_done}, 32'd1);
        tick();
        start = 1'b0;
        chk("t3_fin_start_busy", {31'd0, d0_busy}, 32'd0);
        chk("t3_fin_start_valid", {31'd0, d0_valid}, 32'd0);
        tick();
        chk("t3_idle_busy", {31'd0, d0_busy}, 32'd0);

        // 4: abort on the 3rd byte transfer
        hash_in = 32'h811C9DC5;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("t4_idx2", {29'd0, d0_idx}, 32'd2);
        chk("t4_byte2", {24'd0, d0_data}, 32'h9D);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t4_busy", {31'd0, d0_busy}, 32'd0);
        chk("t4_valid", {31'd0, d0_valid}, 32'd0);
        chk("t4_idx", {29'd0, d0_idx}, 32'd0);
        chk("t4_done", {31'd0, d0_done}, 32'd0);
        chk("t4_clr", {31'd0, d0_clr}, 32'd0);
        tick();
        chk("t4_done2", {31'd0, d0_done}, 32'd0);
        chk("t4_clr2", {31'd0, d0_clr}, 32'd0);

        // 5: start together with abort in IDLE
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("t5_busy", {31'd0, d0_busy}, 32'd0);
        chk("t5_valid", {31'd0, d0_valid}, 32'd0);
        tick();
        chk("t5_busy2", {31'd0, d0_busy}, 32'd0);

        // 6: reset after the first byte, then a clean read
        hash_in = 32'h811C9DC5;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("t6_idx1", {29'd0, d0_idx}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_data", {24'd0, d0_data}, 32'd0);
        chk("t6_valid", {31'd0, d0_valid}, 32'd0);
        chk("t6_busy", {31'd0, d0_busy}, 32'd0);
        chk("t6_done", {31'd0, d0_done}, 32'd0);
        chk("t6_clr", {31'd0, d0_clr}, 32'd0);
        chk("t6_idx", {29'd0, d0_idx}, 32'd0);
        run_read("t6r", 32'hE40C292C, A_BE, A_LE);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
